// File: rtl/vedic_mac_accum_if.sv
// Product-in / sum-out handshake bundle shared by the accumulator and its neighbours.
// The master is the side that produces products and consumes results.
interface vedic_mac_accum_if #(
  parameter int ACC_W = 16
);
  logic             clear;
  logic [7:0]       prod_in;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;
  logic             busy;

  modport master (
    output clear, prod_in, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_valid, ovf, busy
  );

  modport slave (
    input  clear, prod_in, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_valid, ovf, busy
  );
endinterface

// File: rtl/vedic_mac_accum.sv
// Dot-product accumulator: sums LEN unsigned 8-bit products per block and
// holds the wrapped sum plus an overflow flag until downstream takes it.
module vedic_mac_accum #(
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input logic             clk,
  input logic             rst,
  vedic_mac_accum_if.slave bus
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_int_reg;
  logic             ovf_reg;
  logic             acc_valid_reg;
  logic             busy_reg;

  // One extra bit on the adder captures the carry-out used for overflow.
  logic [ACC_W:0] sum;
  logic           accept;

  assign sum    = {1'b0, acc_reg} + {{(ACC_W - 7){1'b0}}, bus.prod_in};
  assign accept = bus.prod_valid && (state_reg == ACCUM);

  assign bus.prod_ready = (state_reg == ACCUM) && !rst;
  assign bus.acc_out    = acc_out_reg;
  assign bus.acc_valid  = acc_valid_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.busy       = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_int_reg   <= 1'b0;
      acc_out_reg   <= '0;
      acc_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (bus.clear) begin
      // Flush wins over any handshake in the same cycle; acc_out is left alone.
      state_reg     <= ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      ovf_int_reg   <= 1'b0;
      acc_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (cnt_reg == CNT_LAST) begin
              acc_out_reg   <= sum[ACC_W-1:0];
              ovf_reg       <= ovf_int_reg | sum[ACC_W];
              acc_valid_reg <= 1'b1;
              state_reg     <= HOLD;
              acc_reg       <= '0;
              cnt_reg       <= '0;
              ovf_int_reg   <= 1'b0;
              busy_reg      <= 1'b0;
            end else begin
              acc_reg     <= sum[ACC_W-1:0];
              ovf_int_reg <= ovf_int_reg | sum[ACC_W];
              cnt_reg     <= cnt_reg + CNT_ONE;
              busy_reg    <= 1'b1;
            end
          end
        end
        HOLD: begin
          // acc_valid is always high here, so acc_ready alone completes the handshake.
          if (bus.acc_ready) begin
            acc_valid_reg <= 1'b0;
            state_reg     <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end
endmodule
